chrono_timer_ctrl: RTL and testbench
====================================

// Module: chrono_timer_ctrl
// PURPOSE
//  Sequencer for the seconds/minutes counter pair behind the VGA clock display.
//  Runs a stopwatch mode (count up) and a countdown-timer mode (count down, edit, alarm).
//  Issues single-cycle step/clear strobes and the count direction to both 6-bit counters.
//  Reads their current values back to decide carries, borrows and when the timer expires.
// PARAMETERS
//  ALARM_SECS  10  number of tick_1hz strobes the alarm output stays high (1..63)
// PORTS
//  clk          in   1  system clock, single clock domain
//  reset        in   1  asynchronous, active-low; all state and outputs cleared
//  tick_1hz     in   1  one-clk strobe once per second, spacing >= 4 clk
//  btn_start    in   1  debounced level; rising edge = start/stop toggle
//  btn_mode     in   1  debounced level; rising edge = stopwatch<->timer
//  btn_clear    in   1  debounced level; rising edge = clear counters
//  btn_inc_min  in   1  debounced level; rising edge = +1 minute (timer edit only)
//  btn_inc_sec  in   1  debounced level; rising edge = +1 second (timer edit only)
//  sec_val      in   6  current seconds counter value (0..59)
//  min_val      in   6  current minutes counter value (0..59)
//  sec_step     out  1  one-clk pulse: seconds counter steps one in dir_up direction
//  min_step     out  1  one-clk pulse: minutes counter steps one in dir_up direction
//  dir_up       out  1  1 = count up (wrap 59->0), 0 = count down (wrap 0->59)
//  cnt_clr      out  1  one-clk pulse: both counters load 0
//  mode_timer   out  1  0 = stopwatch, 1 = timer
//  running      out  1  1 in SW_RUN or TM_RUN
//  alarm        out  1  high in ALARM state
//  state        out  3  encoded FSM state for debug/display
// BEHAVIOUR
//  Reset: state=SW_IDLE (0); all outputs 0; button edge registers 0; alarm counter 0.
//  States: SW_IDLE=0 SW_RUN=1 TM_EDIT=2 TM_RUN=3 TM_PAUSE=4 ALARM=5; 6,7 -> SW_IDLE.
//  Edge detect: one register per button; edge = level & ~prev. Held buttons act once.
//  All outputs registered: strobes appear the clk after the causing tick/edge.
//  dir_up = 0 only in TM_RUN; 1 otherwise; updates with the same edge as the strobes.
//  SW_IDLE: start -> SW_RUN; mode -> TM_EDIT + cnt_clr; clear -> cnt_clr.
//  SW_RUN: tick -> sec_step; if sec_val==59 also min_step. 59:59 wraps to 00:00.
//    start -> SW_IDLE; mode/clear/inc ignored.
//  TM_EDIT: inc_sec -> sec_step (up); inc_min -> min_step (up); no carry between them.
//    start with sec_val==0 && min_val==0 ignored; otherwise -> TM_RUN.
//    mode -> SW_IDLE + cnt_clr; clear -> cnt_clr.
//  TM_RUN: tick with min_val==0 && sec_val==1 -> sec_step, go ALARM.
//    tick with sec_val==0 && min_val!=0 -> sec_step + min_step (borrow).
//    tick otherwise -> sec_step. start -> TM_PAUSE. inc/mode ignored.
//    clear -> cnt_clr, go TM_EDIT (abort).
//  TM_PAUSE: start -> TM_RUN; clear -> cnt_clr, go TM_EDIT; ticks ignored.
//  ALARM: alarm=1; counter loads ALARM_SECS on entry, decrements per tick;
//    reaching 0 -> TM_EDIT. Any button edge acknowledges -> TM_EDIT immediately.
//    Counters hold 00:00; no strobes in ALARM.
//  Simultaneous events, same clk: clear > start > mode > inc_min > inc_sec;
//    only the highest-priority button acts. A tick in that clk is still
//    serviced per the current state (strobe issued) before the transition.
//  sec_step and min_step may pulse together; cnt_clr never coincides with a step.
//  reset low mid-run: immediate SW_IDLE; strobes drop asynchronously.
// TESTING
//  SW: reset, start, 61 ticks with counter model -> 01:01, one min_step at tick 60.
//  SW wrap: preload 59:59 in model, running, 1 tick -> sec_step+min_step, 00:00.
//  TM: mode, inc_min x2, inc_sec x1 (02:01), start, 121 ticks -> ALARM, alarm=1.
//  ALARM_SECS=3: 3 ticks after expiry -> TM_EDIT, alarm=0; btn edge ends it early.
//  Edit 00:00 + start -> stays TM_EDIT; clear+start same clk -> only cnt_clr.
//  Pause at 01:30, 5 ticks -> no strobes; reset low in TM_RUN -> state 0, outputs 0.

Source files
------------

// File: rtl/chrono_timer_ctrl.sv
// Stopwatch / countdown-timer sequencer for the seconds:minutes display counters.
// Issues registered step/clear strobes and count direction to two external
// 6-bit counters and reads their values back to decide carry, borrow and expiry.
module chrono_timer_ctrl #(
  parameter int ALARM_SECS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_start,
  input  logic       btn_mode,
  input  logic       btn_clear,
  input  logic       btn_inc_min,
  input  logic       btn_inc_sec,
  input  logic [5:0] sec_val,
  input  logic [5:0] min_val,
  output logic       sec_step,
  output logic       min_step,
  output logic       dir_up,
  output logic       cnt_clr,
  output logic       mode_timer,
  output logic       running,
  output logic       alarm,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    SW_IDLE  = 3'd0,
    SW_RUN   = 3'd1,
    TM_EDIT  = 3'd2,
    TM_RUN   = 3'd3,
    TM_PAUSE = 3'd4,
    ALARM    = 3'd5
  } state_t;

  localparam logic [5:0] ALARM_LOAD = 6'(ALARM_SECS);

  state_t     state_q, state_d;
  logic [4:0] btn_prev_q, btn_prev_d;
  logic [5:0] alarm_cnt_q, alarm_cnt_d;
  logic       sec_step_q, sec_step_d;
  logic       min_step_q, min_step_d;
  logic       dir_up_q, dir_up_d;
  logic       cnt_clr_q, cnt_clr_d;
  logic       mode_timer_q, mode_timer_d;
  logic       running_q, running_d;
  logic       alarm_q, alarm_d;

  logic [4:0] btn_now, btn_edge;
  logic       e_clear, e_start, e_mode, e_inc_min, e_inc_sec;
  logic       at_zero;

  // Button edge detection, next-state and registered-output computation
  always_comb begin
    btn_now    = {btn_inc_sec, btn_inc_min, btn_mode, btn_start, btn_clear};
    btn_edge   = btn_now & ~btn_prev_q;
    btn_prev_d = btn_now;
    e_clear    = btn_edge[0];
    e_start    = btn_edge[1];
    e_mode     = btn_edge[2];
    e_inc_min  = btn_edge[3];
    e_inc_sec  = btn_edge[4];
    at_zero    = (sec_val == 6'd0) && (min_val == 6'd0);

    state_d     = state_q;
    alarm_cnt_d = alarm_cnt_q;
    sec_step_d  = 1'b0;
    min_step_d  = 1'b0;
    cnt_clr_d   = 1'b0;

    case (state_q)
      SW_IDLE: begin
        if (e_clear) begin
          cnt_clr_d = 1'b1;
        end else if (e_start) begin
          state_d = SW_RUN;
        end else if (e_mode) begin
          state_d   = TM_EDIT;
          cnt_clr_d = 1'b1;
        end
      end
      SW_RUN: begin
        if (tick_1hz) begin
          sec_step_d = 1'b1;
          min_step_d = (sec_val == 6'd59);
        end
        if (e_start) state_d = SW_IDLE;
      end
      TM_EDIT: begin
        if (e_clear) begin
          cnt_clr_d = 1'b1;
        end else if (e_start) begin
          if (!at_zero) state_d = TM_RUN;
        end else if (e_mode) begin
          state_d   = SW_IDLE;
          cnt_clr_d = 1'b1;
        end else if (e_inc_min) begin
          min_step_d = 1'b1;
        end else if (e_inc_sec) begin
          sec_step_d = 1'b1;
        end
      end
      TM_RUN: begin
        // An abort clears the counters, so any tick in the same clk is moot
        if (e_clear) begin
          cnt_clr_d = 1'b1;
          state_d   = TM_EDIT;
        end else begin
          if (tick_1hz) begin
            if (min_val == 6'd0 && sec_val <= 6'd1) begin
              sec_step_d  = (sec_val == 6'd1);
              state_d     = ALARM;
              alarm_cnt_d = ALARM_LOAD;
            end else if (sec_val == 6'd0) begin
              sec_step_d = 1'b1;
              min_step_d = 1'b1;
            end else begin
              sec_step_d = 1'b1;
            end
          end
          // Expiry outranks a pause requested in the same clk
          if (e_start && state_d != ALARM) state_d = TM_PAUSE;
        end
      end
      TM_PAUSE: begin
        if (e_clear) begin
          cnt_clr_d = 1'b1;
          state_d   = TM_EDIT;
        end else if (e_start) begin
          state_d = TM_RUN;
        end
      end
      ALARM: begin
        if (|btn_edge) begin
          state_d     = TM_EDIT;
          alarm_cnt_d = 6'd0;
        end else if (tick_1hz) begin
          if (alarm_cnt_q <= 6'd1) begin
            state_d     = TM_EDIT;
            alarm_cnt_d = 6'd0;
          end else begin
            alarm_cnt_d = alarm_cnt_q - 6'd1;
          end
        end
      end
      default: state_d = SW_IDLE;
    endcase

    // Down direction covers both the clk that enters TM_RUN and the final
    // step issued while leaving it, so every countdown strobe sees dir_up=0
    dir_up_d     = !((state_q == TM_RUN) || (state_d == TM_RUN));
    mode_timer_d = (state_d == TM_EDIT) || (state_d == TM_RUN) ||
                   (state_d == TM_PAUSE) || (state_d == ALARM);
    running_d    = (state_d == SW_RUN) || (state_d == TM_RUN);
    alarm_d      = (state_d == ALARM);
  end

  // State, edge history, alarm counter and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= SW_IDLE;
      btn_prev_q   <= 5'd0;
      alarm_cnt_q  <= 6'd0;
      sec_step_q   <= 1'b0;
      min_step_q   <= 1'b0;
      dir_up_q     <= 1'b0;
      cnt_clr_q    <= 1'b0;
      mode_timer_q <= 1'b0;
      running_q    <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      btn_prev_q   <= btn_prev_d;
      alarm_cnt_q  <= alarm_cnt_d;
      sec_step_q   <= sec_step_d;
      min_step_q   <= min_step_d;
      dir_up_q     <= dir_up_d;
      cnt_clr_q    <= cnt_clr_d;
      mode_timer_q <= mode_timer_d;
      running_q    <= running_d;
      alarm_q      <= alarm_d;
    end
  end

  assign sec_step   = sec_step_q;
  assign min_step   = min_step_q;
  assign dir_up     = dir_up_q;
  assign cnt_clr    = cnt_clr_q;
  assign mode_timer = mode_timer_q;
  assign running    = running_q;
  assign alarm      = alarm_q;
  assign state      = state_q;

endmodule

// File: tb/tb_chrono_timer_ctrl.sv
// Bench for chrono_timer_ctrl: emulates the two display counters, keeps an
// expected time in plain seconds, and checks values and states step by step.
module tb_chrono_timer_ctrl;

  localparam logic [4:0] B_CLR   = 5'b00001;
  localparam logic [4:0] B_START = 5'b00010;
  localparam logic [4:0] B_MODE  = 5'b00100;
  localparam logic [4:0] B_MIN   = 5'b01000;
  localparam logic [4:0] B_SEC   = 5'b10000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       btn_start = 1'b0, btn_mode = 1'b0, btn_clear = 1'b0;
  logic       btn_inc_min = 1'b0, btn_inc_sec = 1'b0;
  logic [5:0] sec_c = 6'd0, min_c = 6'd0;
  logic       sec_step, min_step, dir_up, cnt_clr, mode_timer, running, alarm;
  logic [2:0] state;

  logic       preload_req = 1'b0;
  logic [5:0] pre_sec = 6'd0, pre_min = 6'd0;
  int         n_sec = 0, n_min = 0, n_both = 0;
  int         errors = 0, checks = 0;

  chrono_timer_ctrl #(.ALARM_SECS(3)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
    .btn_start(btn_start), .btn_mode(btn_mode), .btn_clear(btn_clear),
    .btn_inc_min(btn_inc_min), .btn_inc_sec(btn_inc_sec),
    .sec_val(sec_c), .min_val(min_c),
    .sec_step(sec_step), .min_step(min_step), .dir_up(dir_up),
    .cnt_clr(cnt_clr), .mode_timer(mode_timer), .running(running),
    .alarm(alarm), .state(state)
  );

  always #5 clk = ~clk;

  // The external 6-bit modulo-60 counters driven by the strobes
  always @(posedge clk) begin
    if (preload_req) begin
      sec_c <= pre_sec;
      min_c <= pre_min;
    end else if (cnt_clr) begin
      sec_c <= 6'd0;
      min_c <= 6'd0;
    end else begin
      if (sec_step) sec_c <= dir_up ? ((sec_c == 6'd59) ? 6'd0 : sec_c + 6'd1)
                                    : ((sec_c == 6'd0) ? 6'd59 : sec_c - 6'd1);
      if (min_step) min_c <= dir_up ? ((min_c == 6'd59) ? 6'd0 : min_c + 6'd1)
                                    : ((min_c == 6'd0) ? 6'd59 : min_c - 6'd1);
    end
    if (sec_step) n_sec <= n_sec + 1;
    if (min_step) n_min <= n_min + 1;
    if (sec_step && min_step) n_both <= n_both + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int tval();
    return int'(min_c) * 60 + int'(sec_c);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    @(negedge clk);
    tick_1hz = 1'b0;
    cyc(4);
  endtask

  task automatic press(input logic [4:0] b);
    {btn_inc_sec, btn_inc_min, btn_mode, btn_start, btn_clear} = b;
    @(negedge clk);
    {btn_inc_sec, btn_inc_min, btn_mode, btn_start, btn_clear} = 5'd0;
    cyc(3);
  endtask

  task automatic press_n(input logic [4:0] b, input int n);
    for (int i = 0; i < n; i++) press(b);
  endtask

  initial begin
    int model, snap, snap2, n, m, s, total, k;

    // Reset held low
    cyc(3);
    chk("rst_state", state, 3'd0);
    chk("rst_outs", {sec_step, min_step, dir_up, cnt_clr, mode_timer, running, alarm}, 7'd0);
    reset = 1'b1;
    cyc(2);
    chk("idle_state", state, 3'd0);
    chk("idle_dir_up", dir_up, 1'b1);
    chk("idle_mode", mode_timer, 1'b0);

    // Stopwatch: 61 ticks from 00:00
    press(B_START);
    chk("sw_run_state", state, 3'd1);
    chk("sw_running", running, 1'b1);
    model = 0;
    snap = n_min;
    for (int i = 1; i <= 61; i++) begin
      tick();
      model = (model + 1) % 3600;
      if (i == 59) chk("sw_min_before_60", n_min - snap, 0);
      if (i == 60) chk("sw_min_at_60", n_min - snap, 1);
    end
    chk("sw_61_value", tval(), model);
    chk("sw_61_mmss", {min_c, sec_c}, {6'd1, 6'd1});

    // Stopwatch wrap from 59:59
    press(B_START);
    chk("sw_stop_state", state, 3'd0);
    pre_sec = 6'd59;
    pre_min = 6'd59;
    preload_req = 1'b1;
    @(negedge clk);
    preload_req = 1'b0;
    press(B_START);
    snap = n_both;
    tick();
    chk("sw_wrap_both", n_both - snap, 1);
    chk("sw_wrap_value", tval(), 0);

    // Timer edit and full countdown from 02:01
    press(B_START);
    press(B_MODE);
    chk("tm_edit_state", state, 3'd2);
    chk("tm_mode", mode_timer, 1'b1);
    chk("tm_edit_cleared", tval(), 0);
    press(B_START);
    chk("tm_zero_start", state, 3'd2);
    press_n(B_MIN, 2);
    press(B_SEC);
    chk("tm_edit_value", tval(), 121);
    press(B_START);
    chk("tm_run_state", state, 3'd3);
    chk("tm_dir_down", dir_up, 1'b0);
    model = 121;
    for (int i = 1; i <= 121; i++) begin
      tick();
      model--;
      if (i == 2) chk("tm_borrow", tval(), model);
      if (i == 120) begin
        chk("tm_one_left", tval(), 1);
        chk("tm_still_run", state, 3'd3);
      end
    end
    chk("tm_alarm_state", state, 3'd5);
    chk("tm_alarm_out", alarm, 1'b1);
    chk("tm_alarm_zero", tval(), 0);

    // Alarm times out after three ticks
    snap = n_sec;
    tick();
    tick();
    chk("alm_no_strobe", n_sec - snap, 0);
    chk("alm_hold", state, 3'd5);
    tick();
    chk("alm_timeout_state", state, 3'd2);
    chk("alm_timeout_out", alarm, 1'b0);

    // Alarm acknowledged early by a button edge
    press_n(B_SEC, 2);
    press(B_START);
    tick();
    tick();
    chk("ack_alarm_state", state, 3'd5);
    press(B_MODE);
    chk("ack_state", state, 3'd2);
    chk("ack_mode", mode_timer, 1'b1);
    chk("ack_alarm_out", alarm, 1'b0);

    // Clear and start in the same clk: only the clear acts
    press(B_SEC);
    chk("cs_pre", tval(), 1);
    press(B_CLR | B_START);
    chk("cs_state", state, 3'd2);
    chk("cs_value", tval(), 0);

    // Pause at 01:30 ignores ticks
    press(B_MIN);
    press_n(B_SEC, 35);
    press(B_START);
    for (int i = 0; i < 5; i++) tick();
    chk("pause_value_pre", tval(), 90);
    press(B_START);
    chk("pause_state", state, 3'd4);
    snap = n_sec;
    snap2 = n_min;
    for (int i = 0; i < 5; i++) tick();
    chk("pause_no_sec", n_sec - snap, 0);
    chk("pause_no_min", n_min - snap2, 0);
    chk("pause_value", tval(), 90);
    press(B_START);
    tick();
    chk("resume_value", tval(), 89);

    // Asynchronous reset while running
    tick_1hz = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    chk("arst_state", state, 3'd0);
    chk("arst_outs", {sec_step, min_step, dir_up, cnt_clr, mode_timer, running, alarm}, 7'd0);
    @(negedge clk);
    tick_1hz = 1'b0;
    reset = 1'b1;
    cyc(2);
    chk("arst_idle", state, 3'd0);

    // Randomized stopwatch and timer runs
    for (int r = 0; r < 3; r++) begin
      press(B_CLR);
      chk("rnd_clear", tval(), 0);
      press(B_START);
      n = $urandom_range(70, 5);
      model = 0;
      for (int i = 0; i < n; i++) begin
        tick();
        model = (model + 1) % 3600;
      end
      chk("rnd_sw_value", tval(), model);
      press(B_START);
      press(B_MODE);
      m = $urandom_range(2, 0);
      s = $urandom_range(30, 1);
      press_n(B_MIN, m);
      press_n(B_SEC, s);
      total = m * 60 + s;
      chk("rnd_edit_value", tval(), total);
      press(B_START);
      k = $urandom_range(total - 1, 0);
      for (int i = 0; i < k; i++) tick();
      chk("rnd_tm_value", tval(), total - k);
      chk("rnd_tm_state", state, 3'd3);
      for (int i = k; i < total; i++) tick();
      chk("rnd_tm_alarm", state, 3'd5);
      press(B_CLR);
      chk("rnd_ack", state, 3'd2);
      press(B_MODE);
      chk("rnd_back_sw", state, 3'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
